// File: rtl/bw_mult_pkg.sv
// ============================================================================
//  bw_mult_pkg : shared FSM state type and default operand width for the
//                sequential Baugh-Wooley multiplier.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package bw_mult_pkg;

   localparam int DEFAULT_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/bw_mult_row.sv
// ============================================================================
//  bw_mult_row : combinational Baugh-Wooley partial-product row generator.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module bw_mult_row
   import bw_mult_pkg::*;
#(
   parameter int W = DEFAULT_W
) (
   input  logic         a_bit,
   input  logic [W-1:0] b,
   input  logic         last_row,
   output logic [W-1:0] row
);

   logic [W-1:0] pp;
   logic [W-1:0] inv_mask;

   // Ordinary rows invert only the sign column; the sign row inverts all but it.
   always_comb begin
      pp       = b & {W{a_bit}};
      inv_mask = last_row ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
      row      = pp ^ inv_mask;
   end

endmodule

`default_nettype wire

// File: rtl/bw_mult_seq.sv
// ============================================================================
//  bw_mult_seq : sequential signed multiplier, one Baugh-Wooley row per cycle.
//                Define BW_MULT_ACC_EN to add a product accumulator and acc_clr.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module bw_mult_seq
   import bw_mult_pkg::*;
#(
   parameter int W  = DEFAULT_W,
   parameter int CW = $clog2(W)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
`ifdef BW_MULT_ACC_EN
   input  logic           acc_clr,
`endif
   output logic [2*W-1:0] p
);

   localparam logic [CW-1:0] LAST_ROW = CW'(W-1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [2*W-1:0]  psum_q, psum_d;
   logic [2*W-1:0]  row_ext;
   logic [2*W-1:0]  corr;
   logic [2*W-1:0]  sum_next;
   logic [W-1:0]    row;
   logic            a_bit;
   logic            last_row;
   logic            accept;
   logic            finish;

   always_comb begin
      a_bit    = a_q[cnt_q];
      last_row = (cnt_q == LAST_ROW);
   end

   bw_mult_row #(.W(W)) u_row (
      .a_bit    (a_bit),
      .b        (b_q),
      .last_row (last_row),
      .row      (row)
   );

   // The two correction ones ride along with row 0 so each row costs one add.
   always_comb begin
      row_ext = {{W{1'b0}}, row} << cnt_q;
      corr    = '0;
      if (cnt_q == '0) begin
         corr[W]     = 1'b1;
         corr[2*W-1] = 1'b1;
      end
      sum_next = psum_q + row_ext + corr;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      psum_d  = psum_q;
      accept  = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               accept  = 1'b1;
               state_d = RUN;
               a_d     = a;
               b_d     = b;
               psum_d  = '0;
               cnt_d   = '0;
            end
         end
         RUN: begin
            psum_d = sum_next;
            cnt_d  = cnt_q + 1'b1;
            if (last_row) begin
               finish  = 1'b1;
               state_d = DONE;
               cnt_d   = '0;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         psum_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         psum_q  <= psum_d;
      end
   end

`ifdef BW_MULT_ACC_EN
   logic [2*W-1:0] acc_q, acc_d;

   // Clear happens at accept, the add at completion, so they never collide.
   always_comb begin
      acc_d = acc_q;
      if (accept && acc_clr) begin
         acc_d = '0;
      end else if (finish) begin
         acc_d = acc_q + sum_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign p = acc_q;
`else
   logic [2*W-1:0] p_q, p_d;

   always_comb begin
      p_d = p_q;
      if (finish) begin
         p_d = sum_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end

   assign p = p_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bw_mult_seq.sv
// ============================================================================
//  tb_bw_mult_seq : self-checking bench, directed W=6 cases plus W=8 sweep.
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_bw_mult_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;

   logic        in_valid6 = 1'b0, out_ready6 = 1'b0, clr6 = 1'b1;
   logic        in_ready6, out_valid6;
   logic [5:0]  a6 = '0, b6 = '0;
   logic [11:0] p6;
   logic [11:0] acc6_m = '0;

   logic        in_valid8 = 1'b0, out_ready8 = 1'b0, clr8 = 1'b1;
   logic        in_ready8, out_valid8;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [15:0] p8;
   logic [15:0] acc8_m = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bw_mult_seq #(.W(6)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_ready(in_ready6),
      .a(a6), .b(b6), .out_valid(out_valid6), .out_ready(out_ready6),
`ifdef BW_MULT_ACC_EN
      .acc_clr(clr6),
`endif
      .p(p6)
   );

   bw_mult_seq #(.W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
`ifdef BW_MULT_ACC_EN
      .acc_clr(clr8),
`endif
      .p(p8)
   );

   // Reference: plain signed product, optionally summed into a wrapping accumulator.
   task automatic model6(input logic signed [5:0] a, input logic signed [5:0] b,
                         output logic [11:0] exp);
      int prod;
      prod = int'(a) * int'(b);
      if (clr6) acc6_m = '0;
      acc6_m = acc6_m + prod[11:0];
`ifdef BW_MULT_ACC_EN
      exp = acc6_m;
`else
      exp = prod[11:0];
`endif
   endtask

   task automatic model8(input logic signed [7:0] a, input logic signed [7:0] b,
                         output logic [15:0] exp);
      int prod;
      prod = int'(a) * int'(b);
      if (clr8) acc8_m = '0;
      acc8_m = acc8_m + prod[15:0];
`ifdef BW_MULT_ACC_EN
      exp = acc8_m;
`else
      exp = prod[15:0];
`endif
   endtask

   // Offer one operation, scramble operands after accept, wait for out_valid.
   task automatic op6(input logic [5:0] a, input logic [5:0] b, output int lat);
      int n = 0;
      while (!in_ready6 && n < 50) begin @(posedge clk); #1; n++; end
      if (!in_ready6) begin
         errors++; checks++;
         $display("FAIL op6_accept_timeout in_ready=%b expected 1", in_ready6);
      end
      a6 = a; b6 = b; in_valid6 = 1'b1;
      @(posedge clk); #1;
      in_valid6 = 1'b0; a6 = 6'($urandom); b6 = 6'($urandom);
      lat = 0;
      while (!out_valid6 && lat < 50) begin @(posedge clk); #1; lat++; end
      if (!out_valid6) begin
         errors++; checks++;
         $display("FAIL op6_result_timeout out_valid=%b expected 1", out_valid6);
      end
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, output int lat);
      int n = 0;
      while (!in_ready8 && n < 50) begin @(posedge clk); #1; n++; end
      if (!in_ready8) begin
         errors++; checks++;
         $display("FAIL op8_accept_timeout in_ready=%b expected 1", in_ready8);
      end
      a8 = a; b8 = b; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 0;
      while (!out_valid8 && lat < 50) begin @(posedge clk); #1; lat++; end
      if (!out_valid8) begin
         errors++; checks++;
         $display("FAIL op8_result_timeout out_valid=%b expected 1", out_valid8);
      end
   endtask

   task automatic handshake6();
      out_ready6 = 1'b1;
      @(posedge clk); #1;
      out_ready6 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (in_ready6 !== 1'b1) begin errors++; $display("FAIL reset_in_ready6 got=%b exp=1", in_ready6); end
      checks++; if (out_valid6 !== 1'b0) begin errors++; $display("FAIL reset_out_valid6 got=%b exp=0", out_valid6); end
      checks++; if (p6 !== 12'h000) begin errors++; $display("FAIL reset_p6 got=%h exp=000", p6); end
      checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready8 got=%b exp=1", in_ready8); end
      checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid8 got=%b exp=0", out_valid8); end
      checks++; if (p8 !== 16'h0000) begin errors++; $display("FAIL reset_p8 got=%h exp=0000", p8); end
      acc6_m = '0; acc8_m = '0;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [5:0]  av [3] = '{6'h20, 6'h1F, 6'h3F};
      logic [5:0]  bv [3] = '{6'h20, 6'h20, 6'h3F};
      logic [11:0] ev [3] = '{12'h400, 12'hC20, 12'h001};
      logic [11:0] exp;
      int lat;
      clr6 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         model6(av[i], bv[i], exp);
         op6(av[i], bv[i], lat);
         checks++; if (p6 !== ev[i]) begin errors++; $display("FAIL directed_p[%0d] got=%h exp=%h", i, p6, ev[i]); end
         checks++; if (lat != 6) begin errors++; $display("FAIL directed_latency[%0d] got=%0d exp=6", i, lat); end
         handshake6();
         checks++; if (out_valid6 !== 1'b0 || in_ready6 !== 1'b1) begin
            errors++; $display("FAIL directed_release[%0d] out_valid=%b in_ready=%b exp 0/1", i, out_valid6, in_ready6);
         end
      end
   endtask

   task automatic test_stall();
      logic [11:0] exp;
      int lat;
      clr6 = 1'b1;
      model6(6'h3B, 6'h09, exp);  // -5 * 9
      op6(6'h3B, 6'h09, lat);
      for (int k = 0; k < 5; k++) begin
         in_valid6 = 1'b1; a6 = 6'($urandom); b6 = 6'($urandom);
         @(posedge clk); #1;
         checks++; if (out_valid6 !== 1'b1 || p6 !== exp || in_ready6 !== 1'b0) begin
            errors++; $display("FAIL stall_hold[%0d] out_valid=%b p=%h in_ready=%b exp 1/%h/0", k, out_valid6, p6, in_ready6, exp);
         end
      end
      in_valid6 = 1'b0;
      handshake6();
      checks++; if (in_ready6 !== 1'b1 || out_valid6 !== 1'b0) begin
         errors++; $display("FAIL stall_release in_ready=%b out_valid=%b exp 1/0", in_ready6, out_valid6);
      end
   endtask

   task automatic test_reset_midrun();
      logic [11:0] exp;
      bit seen = 1'b0;
      int lat;
      clr6 = 1'b1;
      a6 = 6'd13; b6 = 6'd11; in_valid6 = 1'b1;
      @(posedge clk); #1;
      in_valid6 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (in_ready6 !== 1'b1 || out_valid6 !== 1'b0) begin
         errors++; $display("FAIL midrun_reset_async in_ready=%b out_valid=%b exp 1/0", in_ready6, out_valid6);
      end
      acc6_m = '0; acc8_m = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (out_valid6) seen = 1'b1;
      end
      checks++; if (seen || in_ready6 !== 1'b1) begin
         errors++; $display("FAIL midrun_discard out_valid_seen=%b in_ready=%b exp 0/1", seen, in_ready6);
      end
      clr6 = 1'b0;
      model6(6'd7, 6'h3D, exp);
      op6(6'd7, 6'h3D, lat);
      checks++; if (p6 !== 12'hFEB) begin errors++; $display("FAIL midrun_next_op got=%h exp=feb", p6); end
      handshake6();
   endtask

   task automatic test_back_to_back();
      int t[$];
      int nres = 0;
      logic [11:0] exp;
      clr6 = 1'b1;
      model6(6'h39, 6'h05, exp);  // -7 * 5
      a6 = 6'h39; b6 = 6'h05; in_valid6 = 1'b1; out_ready6 = 1'b1;
      for (int k = 0; k < 60 && t.size() < 3; k++) begin
         bit acc;
         acc = in_valid6 && in_ready6;
         @(posedge clk); #1;
         if (acc) t.push_back(cyc);
         if (out_valid6) begin
            nres++;
            checks++; if (p6 !== 12'hFDD) begin errors++; $display("FAIL b2b_p got=%h exp=fdd", p6); end
         end
      end
      in_valid6 = 1'b0;
      checks++; if (t.size() != 3) begin
         errors++; $display("FAIL b2b_accepts got=%0d exp=3", t.size());
      end else begin
         checks++; if (t[1] - t[0] != 8 || t[2] - t[1] != 8) begin
            errors++; $display("FAIL b2b_interval got=%0d,%0d exp=8,8", t[1] - t[0], t[2] - t[1]);
         end
      end
      checks++; if (nres != 2) begin errors++; $display("FAIL b2b_results got=%0d exp=2", nres); end
      // Drain the third operation.
      for (int k = 0; k < 20 && !in_ready6; k++) begin @(posedge clk); #1; end
      out_ready6 = 1'b0;
   endtask

`ifdef BW_MULT_ACC_EN
   task automatic test_accumulate();
      logic [11:0] exp;
      int lat;
      clr6 = 1'b1;
      model6(6'd3, 6'd4, exp);
      op6(6'd3, 6'd4, lat);
      checks++; if (p6 !== 12'h00C) begin errors++; $display("FAIL acc_first got=%h exp=00c", p6); end
      handshake6();
      clr6 = 1'b0;
      model6(6'd5, 6'h3E, exp);
      op6(6'd5, 6'h3E, lat);
      checks++; if (p6 !== 12'h002) begin errors++; $display("FAIL acc_second got=%h exp=002", p6); end
      handshake6();
   endtask
`endif

   task automatic test_random_sweep();
      logic [7:0]  ca [4] = '{8'h80, 8'h80, 8'h7F, 8'h7F};
      logic [7:0]  cb [4] = '{8'h80, 8'h7F, 8'h80, 8'h7F};
      logic [7:0]  a, b;
      logic [15:0] exp;
      int lat, stall;
      for (int i = 0; i < 3000; i++) begin
         if (i < 4) begin a = ca[i]; b = cb[i]; end
         else begin a = 8'($urandom); b = 8'($urandom); end
         clr8 = 1'($urandom_range(0, 1));
         model8(a, b, exp);
         op8(a, b, lat);
         checks++; if (p8 !== exp || lat != 8) begin
            errors++; $display("FAIL sweep[%0d] a=%h b=%h p=%h exp=%h lat=%0d exp_lat=8", i, a, b, p8, exp, lat);
         end
         stall = $urandom_range(0, 3);
         repeat (stall) @(posedge clk);
         #1;
         checks++; if (out_valid8 !== 1'b1 || p8 !== exp) begin
            errors++; $display("FAIL sweep_stall[%0d] out_valid=%b p=%h exp 1/%h", i, out_valid8, p8, exp);
         end
         out_ready8 = 1'b1;
         @(posedge clk); #1;
         out_ready8 = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_reset_midrun();
      test_back_to_back();
`ifdef BW_MULT_ACC_EN
      test_accumulate();
`endif
      test_random_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
